// File: rtl/fifo_axis_reader.sv
// Drains a show-ahead FIFO read port and presents the words as an AXI4-Stream
// master with programmable packet length, optional burst hold-off and a 2-entry skid buffer.
module fifo_axis_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    output logic                  fifo_rd_o,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    input  logic                  fifo_empty_i,
    input  logic [ADDR_WIDTH:0]   fifo_used_words_i,
    input  logic [LEN_WIDTH-1:0]  pkt_len_i,
    input  logic                  burst_mode_i,
    output logic [DATA_WIDTH-1:0] m_tdata_o,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic                  m_tlast_o,
    output logic                  busy_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [LEN_WIDTH-1:0] FIFO_DEPTH = LEN_WIDTH'(2 ** ADDR_WIDTH);

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   word_cnt_q, word_cnt_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [1:0]             buf_cnt_q, buf_cnt_d;
    logic [DATA_WIDTH:0]    ent0_q, ent0_d;
    logic [DATA_WIDTH:0]    ent1_q, ent1_d;

    logic [LEN_WIDTH-1:0]   threshold;
    logic [LEN_WIDTH-1:0]   used_ext;
    logic                   start_ok;
    logic                   push;
    logic                   xfer;
    logic                   last_word;
    logic [DATA_WIDTH:0]    push_entry;

    // A packet longer than the FIFO can never be fully buffered, so cap the wait at a full FIFO.
    assign threshold  = (pkt_len_i < FIFO_DEPTH) ? pkt_len_i : FIFO_DEPTH;
    assign used_ext   = LEN_WIDTH'(fifo_used_words_i);
    assign start_ok   = (pkt_len_i != '0) &&
                        (burst_mode_i ? (used_ext >= threshold) : !fifo_empty_i);

    assign push       = (state_q == STREAM) && !fifo_empty_i && (buf_cnt_q < 2'd2);
    assign xfer       = m_tvalid_o && m_tready_i;
    assign last_word  = (word_cnt_q == (len_q - 1'b1));
    assign push_entry = {last_word, fifo_rd_data_i};

    assign fifo_rd_o  = push;
    assign m_tvalid_o = (buf_cnt_q != 2'd0);
    assign m_tdata_o  = ent0_q[DATA_WIDTH-1:0];
    assign m_tlast_o  = ent0_q[DATA_WIDTH];
    assign busy_o     = (state_q == STREAM) || (buf_cnt_q != 2'd0);

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        case (state_q)
            IDLE: begin
                len_d      = pkt_len_i;
                word_cnt_d = '0;
                if (start_ok) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (push) begin
                    if (last_word) begin
                        state_d    = IDLE;
                        word_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Entry 0 is always the head; entry 1 only holds a word while entry 0 is stalled.
    always_comb begin
        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        buf_cnt_d = buf_cnt_q;
        case ({push, xfer})
            2'b10: begin
                if (buf_cnt_q == 2'd0) begin
                    ent0_d = push_entry;
                end else begin
                    ent1_d = push_entry;
                end
                buf_cnt_d = buf_cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d    = ent1_q;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b11: begin
                if (buf_cnt_q == 2'd1) begin
                    ent0_d = push_entry;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = push_entry;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            len_q      <= '0;
            buf_cnt_q  <= 2'd0;
            ent0_q     <= '0;
            ent1_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            buf_cnt_q  <= buf_cnt_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
        end
    end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Directed bench for fifo_axis_reader: a queue-based show-ahead FIFO model feeds the DUT
// and a negedge monitor captures stream transfers for ordered, hand-computed comparison.
module tb_fifo_axis_reader;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_rd_o;
    logic [DW-1:0] fifo_rd_data_i = '0;
    logic          fifo_empty_i = 1'b1;
    logic [AW:0]   fifo_used_words_i = '0;
    logic [LW-1:0] pkt_len_i = '0;
    logic          burst_mode_i = 1'b0;
    logic [DW-1:0] m_tdata_o;
    logic          m_tvalid_o;
    logic          m_tready_i = 1'b0;
    logic          m_tlast_o;
    logic          busy_o;

    fifo_axis_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .fifo_rd_o         (fifo_rd_o),
        .fifo_rd_data_i    (fifo_rd_data_i),
        .fifo_empty_i      (fifo_empty_i),
        .fifo_used_words_i (fifo_used_words_i),
        .pkt_len_i         (pkt_len_i),
        .burst_mode_i      (burst_mode_i),
        .m_tdata_o         (m_tdata_o),
        .m_tvalid_o        (m_tvalid_o),
        .m_tready_i        (m_tready_i),
        .m_tlast_o         (m_tlast_o),
        .busy_o            (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int            c;
    } rx_t;

    int            vec = 0;
    int            errs = 0;
    int            cyc = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] wr_pend[$];
    int            wr_gap = 0;
    int            gap_cnt = 0;
    int            mark_target = 0;
    int            mark_cyc = -1;
    int            pop_cyc[$];
    rx_t           rx[$];
    int            rdy_mode = 0;
    logic          rdy_fixed = 1'b1;
    int            pat_idx = 0;
    logic          have_prev = 1'b0;
    logic          prev_v, prev_r, prev_l;
    logic [DW-1:0] prev_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        pat_idx    <= pat_idx + 1;
        m_tready_i <= (rdy_mode != 0) ? (pat_idx % 3 == 0) : rdy_fixed;
    end

    // Show-ahead FIFO model: pop and write take effect at the clock edge.
    always @(posedge clk) begin
        if (fifo_rd_o) begin
            check("rd_while_empty", {31'd0, fifo_empty_i}, 32'd0);
            if (fq.size() > 0) void'(fq.pop_front());
            pop_cyc.push_back(cyc);
        end
        if (wr_pend.size() > 0 && fq.size() < 8) begin
            if (gap_cnt == 0) begin
                fq.push_back(wr_pend.pop_front());
                gap_cnt = wr_gap;
                if (mark_cyc < 0 && fq.size() == mark_target) mark_cyc = cyc;
            end else begin
                gap_cnt--;
            end
        end
        fifo_empty_i      <= (fq.size() == 0);
        fifo_rd_data_i    <= (fq.size() > 0) ? fq[0] : '0;
        fifo_used_words_i <= (AW+1)'(fq.size());
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev && prev_v && !prev_r) begin
                check("hold_valid", {31'd0, m_tvalid_o}, 32'd1);
                check("hold_data", {24'd0, m_tdata_o}, {24'd0, prev_d});
                check("hold_last", {31'd0, m_tlast_o}, {31'd0, prev_l});
            end
            if (m_tvalid_o && m_tready_i) rx.push_back('{d: m_tdata_o, l: m_tlast_o, c: cyc});
            prev_v    = m_tvalid_o;
            prev_r    = m_tready_i;
            prev_d    = m_tdata_o;
            prev_l    = m_tlast_o;
            have_prev = 1'b1;
        end
    end

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy_o && k < 300) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check(tag, {31'd0, busy_o}, 32'd0);
    endtask

    task automatic check_words(input string tag, input int n, input logic [DW-1:0] first, input int len);
        rx_t e;
        check({tag, "_count"}, rx.size(), n);
        for (int i = 0; i < n && rx.size() > 0; i++) begin
            e = rx.pop_front();
            check({tag, "_data"}, {24'd0, e.d}, {24'd0, first + DW'(i)});
            check({tag, "_last"}, {31'd0, e.l}, {31'd0, ((i + 1) % len == 0)});
        end
        rx.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with five words sitting in the FIFO.
        pkt_len_i = 16'd5;
        for (int i = 0; i < 5; i++) wr_pend.push_back(8'hA1 + 8'(i));
        repeat (8) @(negedge clk);
        check("rst_tvalid", {31'd0, m_tvalid_o}, 32'd0);
        check("rst_tlast", {31'd0, m_tlast_o}, 32'd0);
        check("rst_tdata", {24'd0, m_tdata_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_fifo_rd", {31'd0, fifo_rd_o}, 32'd0);
        check("rst_no_pops", pop_cyc.size(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_1clk_tvalid", {31'd0, m_tvalid_o}, 32'd0);
        check("rel_1clk_fifo_rd", {31'd0, fifo_rd_o}, 32'd1);
        @(negedge clk);
        check("rel_2clk_tvalid", {31'd0, m_tvalid_o}, 32'd1);
        check("rel_2clk_tdata", {24'd0, m_tdata_o}, 32'hA1);
        wait_rx(5, 50);
        check_words("rst_pkt", 5, 8'hA1, 5);
        wait_idle("rst_pkt_idle");

        // Zero length with a full FIFO: no pops, stays idle.
        pkt_len_i = 16'd0;
        pop_cyc.delete();
        for (int i = 0; i < 8; i++) wr_pend.push_back(8'h11 + 8'(i));
        repeat (14) @(negedge clk);
        check("len0_busy", {31'd0, busy_o}, 32'd0);
        check("len0_fifo_rd", {31'd0, fifo_rd_o}, 32'd0);
        check("len0_tvalid", {31'd0, m_tvalid_o}, 32'd0);
        check("len0_no_pops", pop_cyc.size(), 32'd0);

        // Basic: two packets of four with one pop bubble between them.
        pkt_len_i = 16'd4;
        wait_rx(8, 60);
        check_words("basic", 8, 8'h11, 4);
        check("basic_pops", pop_cyc.size(), 32'd8);
        if (pop_cyc.size() >= 5) begin
            check("basic_pkt_span", pop_cyc[3] - pop_cyc[0], 32'd3);
            check("basic_bubble", pop_cyc[4] - pop_cyc[3], 32'd2);
        end
        wait_idle("basic_idle");

        // Backpressure: ready pattern 1,0,0 repeating, packets of three.
        pkt_len_i = 16'd0;
        rdy_mode  = 1;
        for (int i = 0; i < 9; i++) wr_pend.push_back(8'h21 + 8'(i));
        repeat (12) @(negedge clk);
        pkt_len_i = 16'd3;
        wait_rx(9, 200);
        check_words("bp", 9, 8'h21, 3);
        rdy_mode = 0;
        wait_idle("bp_idle");

        // Burst mode: hold off until five words are buffered, then stream back-to-back.
        pkt_len_i    = 16'd5;
        burst_mode_i = 1'b1;
        pop_cyc.delete();
        mark_target  = 5;
        mark_cyc     = -1;
        wr_gap       = 2;
        gap_cnt      = 0;
        for (int i = 0; i < 5; i++) wr_pend.push_back(8'h31 + 8'(i));
        wait_rx(5, 100);
        check("burst_pops", pop_cyc.size(), 32'd5);
        if (pop_cyc.size() == 5) begin
            check("burst_start", pop_cyc[0], mark_cyc + 2);
            check("burst_b2b", pop_cyc[4] - pop_cyc[0], 32'd4);
        end
        if (rx.size() == 5) check("burst_tvalid_cont", rx[4].c - rx[0].c, 32'd4);
        check_words("burst", 5, 8'h31, 5);
        wait_idle("burst_idle");

        // Packet longer than the FIFO: start at a full FIFO, tlast only on word 20.
        pkt_len_i   = 16'd20;
        pop_cyc.delete();
        mark_target = 8;
        mark_cyc    = -1;
        wr_gap      = 0;
        gap_cnt     = 0;
        for (int i = 0; i < 20; i++) wr_pend.push_back(8'h40 + 8'(i));
        wait_rx(20, 200);
        if (pop_cyc.size() > 0) check("long_start", pop_cyc[0], mark_cyc + 2);
        check_words("long", 20, 8'h40, 20);
        wait_idle("long_idle");

        // Length one: every word is a packet.
        burst_mode_i = 1'b0;
        pkt_len_i    = 16'd1;
        for (int i = 0; i < 3; i++) wr_pend.push_back(8'h61 + 8'(i));
        wait_rx(3, 50);
        check_words("len1", 3, 8'h61, 1);
        wait_idle("len1_idle");

        // Reset mid-packet with a stalled consumer.
        pkt_len_i = 16'd0;
        rdy_fixed = 1'b0;
        for (int i = 0; i < 6; i++) wr_pend.push_back(8'h71 + 8'(i));
        repeat (10) @(negedge clk);
        pkt_len_i = 16'd6;
        repeat (6) @(negedge clk);
        check("mid_tvalid", {31'd0, m_tvalid_o}, 32'd1);
        check("mid_tdata", {24'd0, m_tdata_o}, 32'h71);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", {31'd0, m_tvalid_o}, 32'd0);
        check("mid_rst_tdata", {24'd0, m_tdata_o}, 32'd0);
        check("mid_rst_tlast", {31'd0, m_tlast_o}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        check("mid_rst_fifo_rd", {31'd0, fifo_rd_o}, 32'd0);
        pkt_len_i = 16'd4;
        rdy_fixed = 1'b1;
        rx.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_rx(4, 50);
        check_words("after_rst", 4, 8'h73, 4);
        wait_idle("after_rst_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
